logic_sweep_eval: RTL and testbench
===================================

Name: logic_sweep_eval

Overview:
- Parametrised, clocked successor to the team's fixed 3-input behavioural gate circuits.
- On a start command, a counter sweeps every 2^N_IN input vector through one of two functions:
  - the generalised fixed function, or
  - a programmable truth-table LUT.
- Each evaluation is streamed out, and the block builds a captured result map plus a ones count.
- Used as a self-checking stimulus/evaluation engine beside combinational blocks and their testbenches.

Parameters:
- N_IN, 3, number of function inputs; legal range 2..8.
- TT_W, 2**N_IN, truth-table width in bits. Derived; do not override.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a sweep; sampled only in IDLE.
- hold  in  1  stall the sweep while high.
- mode  in  1  function select: 0 = fixed function, 1 = LUT. Latched at start.
- lut_load  in  1  write lut_data into the LUT register; honoured only in IDLE.
- lut_data  in  TT_W  LUT contents; bit k = output for input vector k.
- vec_out  out  N_IN  input vector just evaluated; bit N_IN-1 = A (MSB).
- x_out  out  1  function result for vec_out.
- valid  out  1  vec_out and x_out are valid this cycle.
- busy  out  1  sweep in progress.
- done  out  1  one-cycle pulse when the sweep completes.
- result_map  out  TT_W  captured results; bit k = f(k).
- ones_count  out  N_IN+1  number of vectors that evaluated to 1.

Behaviour:
- Interface: single clock clk; reset rst_n is asynchronous and active-low.
- Reset values (applied immediately on rst_n low):
  - state = IDLE.
  - vec_out, x_out, valid, busy, done = 0.
  - result_map, ones_count, LUT register, latched mode, counter = 0.
- Fixed function, with A = vec[N_IN-1] and R = OR of vec[N_IN-2:0]:
  - f = 0 when A = 0 and R = 1; otherwise f = 1.
  - For N_IN = 3 this matches the existing A/B/C gate circuit.
- LUT function: f = lut[vec].
- State machine IDLE -> SWEEP -> DONE -> IDLE. Edge numbering below starts at E0.
- IDLE:
  - start = 1 at edge E0 gives: state SWEEP, counter 0, latched mode <= mode, busy <= 1, result_map <= 0, ones_count <= 0.
  - lut_load = 1 in IDLE with start = 0 writes the LUT.
  - lut_load and start together: the load happens and the sweep starts; the sweep uses the new LUT value.
- SWEEP, each edge with hold = 0:
  - vec_out <= counter, x_out <= f(counter), valid <= 1.
  - result_map[counter] <= f(counter); ones_count += f(counter).
  - counter increments.
  - When counter = TT_W-1, the sweep evaluates that vector and goes to DONE. The counter does not wrap.
- SWEEP, edge with hold = 1:
  - counter, result_map and ones_count hold; valid <= 0.
  - vec_out and x_out keep their last values.
- DONE (one edge): valid <= 0, busy <= 0, done <= 1, state IDLE. done deasserts on the next edge.
- Timing with no hold:
  - valid is high for exactly TT_W consecutive cycles after E1..E_TT_W.
  - done is high after edge E_(TT_W+1).
  - Total latency from start is TT_W+1 edges.
- Ignored inputs:
  - start while busy is ignored.
  - lut_load outside IDLE is ignored.
  - mode changes mid-sweep have no effect.
- result_map and ones_count hold their final values until the next start or a reset.
- Reset asserted mid-sweep aborts immediately to reset values. The LUT is also cleared.

Optional Feature:
- Macro: SWEEP_CHECK_EN.
- Defined:
  - Adds input expected (TT_W) and outputs mismatch (1) and first_err (N_IN).
  - expected is sampled at start.
  - At each valid evaluation, f(vec) is compared with expected[vec].
  - On the first difference, mismatch <= 1 and first_err <= vec; later differences do not overwrite these.
  - Both are cleared at start and at reset.
- Undefined: these ports and the comparison logic are absent. All other behaviour is identical.

Test Plan:
- N_IN = 3, mode = 0, start pulse:
  - valid high 8 cycles with vec_out 0..7.
  - x_out sequence 1,0,0,0,1,1,1,1.
  - done pulse one cycle later; result_map = 8'hF1, ones_count = 5.
- LUT load 8'hA5 in IDLE, then mode = 1 and start: result_map = 8'hA5, ones_count = 4, x_out follows the bits of A5 LSB-first.
- hold = 1 for 3 cycles during vec 4:
  - valid low for those 3 cycles, no vector skipped or repeated.
  - done arrives 3 cycles later than nominal; result_map is still 8'hF1.
- Ignored inputs during a mode-0 sweep:
  - start and lut_load = 1 with lut_data = 8'h00 mid-sweep have no effect; the sweep completes normally with result_map = 8'hF1.
  - A later mode-1 sweep returns the previously loaded LUT contents.
- rst_n low at vec 5, then released and started again:
  - On reset, all outputs are 0 immediately, busy = 0 and no done pulse.
  - The restart performs a clean full 8-vector sweep.
- SWEEP_CHECK_EN, expected = 8'hF3, mode 0: mismatch = 1, first_err = 3'd1, reported after the vec 1 evaluation.

Source files
------------

// File: rtl/logic_sweep_eval.sv
`default_nettype none
// ============================================================================
//  Module   : logic_sweep_eval
//  Purpose  : On start, sweeps every 2^N_IN input vector through either the
//             generalised fixed gate function or a programmable truth-table
//             LUT, streams each evaluation, and captures a result map plus a
//             ones count.
//  Options  : SWEEP_CHECK_EN adds an expected-map compare with a sticky
//             first-mismatch report.
//  Revision : 1.0  initial release
// ============================================================================
module logic_sweep_eval #(
    parameter int N_IN = 3,
    parameter int TT_W = 2**N_IN
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              hold,
    input  logic              mode,
    input  logic              lut_load,
    input  logic [TT_W-1:0]   lut_data,
    output logic [N_IN-1:0]   vec_out,
    output logic              x_out,
    output logic              valid,
    output logic              busy,
    output logic              done,
    output logic [TT_W-1:0]   result_map,
    output logic [N_IN:0]     ones_count
`ifdef SWEEP_CHECK_EN
    ,
    input  logic [TT_W-1:0]   expected,
    output logic              mismatch,
    output logic [N_IN-1:0]   first_err
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    // The last vector is all ones because TT_W is 2^N_IN.
    localparam logic [N_IN-1:0] c_last = {N_IN{1'b1}};

    state_t            r_state;
    state_t            w_state_nxt;
    logic [N_IN-1:0]   r_cnt;
    logic              r_mode;
    logic [TT_W-1:0]   r_lut;
`ifdef SWEEP_CHECK_EN
    logic [TT_W-1:0]   r_expected;
`endif

    logic              w_fix;
    logic              w_f;
    logic              w_eval;
    logic              w_last;

    // Fixed function is 0 only when A is low and any lower input is high.
    assign w_fix  = r_cnt[N_IN-1] | ~(|r_cnt[N_IN-2:0]);
    assign w_f    = r_mode ? r_lut[r_cnt] : w_fix;
    assign w_eval = (r_state == SWEEP) && !hold;
    assign w_last = (r_cnt == c_last);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode: the final vector is evaluated before moving to DONE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = SWEEP;
            SWEEP:   if (w_eval && w_last) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Datapath: LUT load, sweep counter, streamed outputs and captured results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_mode     <= 1'b0;
            r_lut      <= '0;
            vec_out    <= '0;
            x_out      <= 1'b0;
            valid      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            result_map <= '0;
            ones_count <= '0;
`ifdef SWEEP_CHECK_EN
            r_expected <= '0;
            mismatch   <= 1'b0;
            first_err  <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    valid <= 1'b0;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    // A load coincident with start lands before the first evaluation.
                    if (lut_load) begin
                        r_lut <= lut_data;
                    end
                    if (start) begin
                        r_cnt      <= '0;
                        r_mode     <= mode;
                        busy       <= 1'b1;
                        result_map <= '0;
                        ones_count <= '0;
`ifdef SWEEP_CHECK_EN
                        r_expected <= expected;
                        mismatch   <= 1'b0;
                        first_err  <= '0;
`endif
                    end
                end
                SWEEP: begin
                    if (!hold) begin
                        vec_out           <= r_cnt;
                        x_out             <= w_f;
                        valid             <= 1'b1;
                        result_map[r_cnt] <= w_f;
                        ones_count        <= ones_count + {{N_IN{1'b0}}, w_f};
                        if (!w_last) begin
                            r_cnt <= r_cnt + 1'b1;
                        end
`ifdef SWEEP_CHECK_EN
                        if ((w_f != r_expected[r_cnt]) && !mismatch) begin
                            mismatch  <= 1'b1;
                            first_err <= r_cnt;
                        end
`endif
                    end else begin
                        valid <= 1'b0;
                    end
                end
                DONE: begin
                    valid <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: begin
                    valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_logic_sweep_eval.sv
`default_nettype none
// ============================================================================
//  Module   : tb_logic_sweep_eval
//  Purpose  : Self-checking bench for logic_sweep_eval (N_IN = 3) with a
//             truth-table reference model and directed plus random sweeps.
//  Revision : 1.0  initial release
// ============================================================================
module tb_logic_sweep_eval;

    localparam int N  = 3;
    localparam int TT = 8;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          hold;
    logic          mode;
    logic          lut_load;
    logic [TT-1:0] lut_data;
    logic [N-1:0]  vec_out;
    logic          x_out;
    logic          valid;
    logic          busy;
    logic          done;
    logic [TT-1:0] result_map;
    logic [N:0]    ones_count;
`ifdef SWEEP_CHECK_EN
    logic [TT-1:0] expected;
    logic          mismatch;
    logic [N-1:0]  first_err;
`endif

    int checks = 0;
    int errors = 0;

    // Reference state: what the LUT should hold and which function a sweep uses.
    logic [TT-1:0] m_lut  = '0;
    logic          m_mode = 1'b0;

    logic_sweep_eval #(.N_IN(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .hold       (hold),
        .mode       (mode),
        .lut_load   (lut_load),
        .lut_data   (lut_data),
        .vec_out    (vec_out),
        .x_out      (x_out),
        .valid      (valid),
        .busy       (busy),
        .done       (done),
        .result_map (result_map),
        .ones_count (ones_count)
`ifdef SWEEP_CHECK_EN
        ,
        .expected   (expected),
        .mismatch   (mismatch),
        .first_err  (first_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Function value straight from the rules: A=1 or all lower inputs 0 gives 1.
    function automatic bit fm(input int v);
        if (m_mode) return m_lut[v];
        return (v >= TT / 2) || ((v % (TT / 2)) == 0);
    endfunction

    function automatic logic [TT-1:0] model_map();
        logic [TT-1:0] m;
        for (int v = 0; v < TT; v++) m[v] = fm(v);
        return m;
    endfunction

    function automatic int model_ones();
        int n = 0;
        for (int v = 0; v < TT; v++) n += int'(fm(v));
        return n;
    endfunction

    // One complete sweep. hold_kind: 0 none, 1 three holds at vec 4, 2 random.
    task automatic sweep(input bit md, input bit ld, input logic [TT-1:0] ld_data,
                         input int hold_kind, input bit interfere);
        int idx = 0;
        int holds = 0;
        int hcnt = 0;
        int edges = 0;
        bit h;
        logic [N-1:0] lv;
        logic lx;
        logic [TT-1:0] emap;
        int eones;
        m_mode = md;
        if (ld) m_lut = ld_data;
        emap  = model_map();
        eones = model_ones();
        lv = vec_out;
        lx = x_out;
        mode = md; start = 1'b1; lut_load = ld; lut_data = ld_data; hold = 1'b0;
`ifdef SWEEP_CHECK_EN
        expected = emap;
`endif
        step(); edges++;
        start = 1'b0; lut_load = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("valid_after_start", 32'(valid), 32'd0);
        chk("map_cleared", 32'(result_map), 32'd0);
        chk("ones_cleared", 32'(ones_count), 32'd0);
        while (idx < TT && edges < 200) begin
            h = 1'b0;
            if (hold_kind == 1 && idx == 4 && hcnt < 3) begin h = 1'b1; hcnt++; end
            else if (hold_kind == 2) h = ($urandom_range(0, 3) == 0);
            hold = h;
            if (interfere) begin
                start    = 1'($urandom);
                lut_load = 1'($urandom);
                lut_data = '0;
                mode     = 1'($urandom);
            end
            step(); edges++;
            if (h) begin
                holds++;
                chk("valid_in_hold", 32'(valid), 32'd0);
                chk("vec_in_hold", 32'(vec_out), 32'(lv));
                chk("x_in_hold", 32'(x_out), 32'(lx));
            end else begin
                chk("valid_eval", 32'(valid), 32'd1);
                chk("vec_eval", 32'(vec_out), 32'(idx));
                chk("x_eval", 32'(x_out), 32'(fm(idx)));
                lv = N'(idx);
                lx = fm(idx);
                idx++;
            end
            chk("busy_in_sweep", 32'(busy), 32'd1);
            chk("done_in_sweep", 32'(done), 32'd0);
        end
        hold = 1'b0; start = 1'b0; lut_load = 1'b0;
        if (idx < TT) chk("sweep_timeout", 32'(idx), 32'(TT));
        step(); edges++;
        chk("done_pulse", 32'(done), 32'd1);
        chk("valid_at_done", 32'(valid), 32'd0);
        chk("busy_at_done", 32'(busy), 32'd0);
        chk("latency", 32'(edges - 1), 32'(TT + 1 + holds));
        chk("result_map", 32'(result_map), 32'(emap));
        chk("ones_count", 32'(ones_count), 32'(eones));
`ifdef SWEEP_CHECK_EN
        chk("no_mismatch", 32'(mismatch), 32'd0);
`endif
        step();
        chk("done_drops", 32'(done), 32'd0);
        chk("map_holds", 32'(result_map), 32'(emap));
        chk("ones_holds", 32'(ones_count), 32'(eones));
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; hold = 1'b0; mode = 1'b0;
        lut_load = 1'b0; lut_data = '0;
`ifdef SWEEP_CHECK_EN
        expected = '0;
`endif
        repeat (3) step();
        chk("rst_vec", 32'(vec_out), 32'd0);
        chk("rst_x", 32'(x_out), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_map", 32'(result_map), 32'd0);
        chk("rst_ones", 32'(ones_count), 32'd0);
        rst_n = 1'b1;
        step();

        // Fixed function sweep.
        sweep(1'b0, 1'b0, '0, 0, 1'b0);
        chk("fixed_map_F1", 32'(result_map), 32'h0F1);
        chk("fixed_ones_5", 32'(ones_count), 32'd5);

        // Standalone LUT load in IDLE, then LUT sweep.
        lut_load = 1'b1; lut_data = 8'hA5;
        step();
        lut_load = 1'b0; m_lut = 8'hA5;
        chk("load_no_busy", 32'(busy), 32'd0);
        sweep(1'b1, 1'b0, '0, 0, 1'b0);
        chk("lut_map_A5", 32'(result_map), 32'h0A5);
        chk("lut_ones_4", 32'(ones_count), 32'd4);

        // Hold for three cycles at vec 4.
        sweep(1'b0, 1'b0, '0, 1, 1'b0);
        chk("hold_map_F1", 32'(result_map), 32'h0F1);

        // Start, lut_load and mode toggling mid-sweep are ignored.
        sweep(1'b0, 1'b0, '0, 0, 1'b1);
        chk("ignored_map_F1", 32'(result_map), 32'h0F1);
        sweep(1'b1, 1'b0, '0, 0, 1'b0);
        chk("lut_kept_A5", 32'(result_map), 32'h0A5);

        // Load and start together: sweep sees the new contents.
        sweep(1'b1, 1'b1, 8'h3C, 0, 1'b0);
        chk("load_start_3C", 32'(result_map), 32'h03C);

        // Reset in the middle of a sweep, right after vec 5 evaluated.
        mode = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        repeat (6) step();
        chk("pre_abort_vec", 32'(vec_out), 32'd5);
        chk("pre_abort_valid", 32'(valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_vec", 32'(vec_out), 32'd0);
        chk("abort_x", 32'(x_out), 32'd0);
        chk("abort_valid", 32'(valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_map", 32'(result_map), 32'd0);
        chk("abort_ones", 32'(ones_count), 32'd0);
        step();
        chk("abort_no_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        m_lut = '0;
        step();
        chk("post_abort_no_done", 32'(done), 32'd0);
        sweep(1'b1, 1'b0, '0, 0, 1'b0);
        chk("lut_cleared", 32'(result_map), 32'd0);
        sweep(1'b0, 1'b0, '0, 0, 1'b0);
        chk("restart_map_F1", 32'(result_map), 32'h0F1);

        // Random LUT contents, modes and hold patterns.
        for (int r = 0; r < 8; r++) begin
            sweep(1'($urandom), 1'($urandom), TT'($urandom), 2, 1'($urandom_range(0, 1)));
        end

`ifdef SWEEP_CHECK_EN
        // Expected map differs from the fixed function only at vector 1.
        mode = 1'b0; start = 1'b1; expected = 8'hF3;
        step();
        start = 1'b0;
        step();
        chk("chk_vec0_clean", 32'(mismatch), 32'd0);
        step();
        chk("chk_mismatch", 32'(mismatch), 32'd1);
        chk("chk_first_err", 32'(first_err), 32'd1);
        repeat (8) step();
        chk("chk_sticky", 32'(mismatch), 32'd1);
        chk("chk_first_err_kept", 32'(first_err), 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
